uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer that shares one UART transmitter among N_REQ byte producers.
//   Grants one requester at a time and latches its byte.
//   Launches the frame with a tick-qualified start, then holds off until the transmitter reports done.
//   Sits between the producers (ALU result, status, echo paths) and the uart_tx instance.
// PARAMETERS
//   NB_DATA       8    byte width presented to the transmitter
//   N_REQ         4    number of requesters
//   LOG2_N_REQ    2    width of grant index (>= clog2(N_REQ))
//   TIMEOUT_TICKS 512  i_valid ticks allowed in BUSY before abort
//   NB_TIMEOUT    10   width of watchdog counter (holds TIMEOUT_TICKS)
// PORTS
//   i_clock        in   1               single system clock, all logic on posedge
//   i_reset_n      in   1               asynchronous active-low reset
//   i_req          in   N_REQ           per-requester level request; held until o_ack
//   i_data         in   N_REQ*NB_DATA   flat byte bus, requester k at [k*NB_DATA +: NB_DATA]
//   i_valid        in   1               baud-tick enable shared with the transmitter
//   i_tx_done      in   1               1-cycle pulse from transmitter: frame finished
//   o_ack          out  N_REQ           1-cycle one-hot pulse: byte of requester k latched
//   o_tx_data      out  NB_DATA         byte to transmitter, stable from LOAD until next grant
//   o_tx_start     out  1               start request to transmitter
//   o_grant_id     out  LOG2_N_REQ      index of current/last granted requester
//   o_busy         out  1               high in every state except IDLE
//   o_frame_done   out  1               1-cycle pulse when i_tx_done is accepted in BUSY
//   o_timeout      out  1               1-cycle pulse when the watchdog aborts BUSY
// BEHAVIOUR
//   Reset (async, i_reset_n=0): state=IDLE, rr pointer=0, all outputs 0 (o_tx_data=0, o_grant_id=0).
//   All outputs are registered. There are no combinational paths from inputs to outputs.
//   FSM states: IDLE, LOAD, BUSY.
//   IDLE:
//     - If |i_req, pick the first set bit searching from rr pointer upward, wrapping at N_REQ-1 -> 0.
//     - Next edge: o_tx_data <= winner byte, o_grant_id <= winner, o_ack[winner] <= 1 for one cycle.
//     - State -> LOAD.
//     - With no request, stay in IDLE; o_tx_start stays 0.
//   LOAD:
//     - o_tx_start=1 (registered, asserted the cycle the state enters LOAD).
//     - On a cycle with i_valid=1: state -> BUSY and o_tx_start -> 0 at the next edge.
//     - Start is therefore seen by exactly one tick.
//     - i_tx_done in LOAD is ignored.
//   BUSY:
//     - Watchdog clears on entry and increments on each i_valid.
//     - i_tx_done=1: o_frame_done pulse, rr pointer <= grant+1 (mod N_REQ), state -> IDLE.
//     - Watchdog == TIMEOUT_TICKS-1 together with i_valid, and no i_tx_done: o_timeout pulse,
//       same pointer advance, state -> IDLE.
//     - i_tx_done and timeout in the same cycle: done wins; o_timeout stays 0.
//   Fairness:
//     - A requester that was just served has the lowest priority on the next arbitration.
//     - With all N_REQ requesting continuously, grants cycle 0,1,..,N_REQ-1,0.
//   Throughput:
//     - IDLE -> LOAD costs one clock; there is no back-to-back grant without passing through IDLE.
//     - Minimum gap between a done in BUSY and the next o_ack is 1 clock.
//   Requests:
//     - i_req is sampled only in IDLE.
//     - Requests that drop before grant are never acked.
//     - o_ack for a requester whose i_req is still high after the ack does not re-grant it immediately.
//   Reset mid-frame returns to IDLE at once. In-flight byte is lost and no o_frame_done is issued.
// TESTING
//   1. Reset, i_req=4'b0100, data[2]=8'hA5, i_valid every 16 clocks, done 160 clk after tick:
//      -> o_ack=4'b0100 one cycle, o_tx_data=8'hA5, o_tx_start high until first tick, one o_frame_done.
//   2. i_req=4'b1111 held, each byte acked then re-requested:
//      -> grant order 0,1,2,3,0 across five frames, exactly one o_ack pulse per frame.
//   3. After serving id 3, i_req=4'b1001 -> grant 0 (wrap); then grant 3; rr pointer never skips.
//   4. No i_tx_done ever, TIMEOUT_TICKS=8, tick every clock:
//      -> o_timeout pulse 8 ticks after BUSY entry, state IDLE, next requester served.
//   5. i_tx_done coincident with final watchdog tick -> o_frame_done=1, o_timeout=0.
//   6. Assert i_reset_n=0 in BUSY -> outputs 0 in the same cycle (async); after release,
//      pending i_req=4'b0010 -> grant 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte producers.
// Grants one requester, latches its byte, issues a tick-qualified start and waits for done or watchdog.
module uart_tx_arbiter #(
    parameter int NB_DATA       = 8,
    parameter int N_REQ         = 4,
    parameter int LOG2_N_REQ    = 2,
    parameter int TIMEOUT_TICKS = 512,
    parameter int NB_TIMEOUT    = 10
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*NB_DATA-1:0] i_data,
    input  logic                     i_valid,
    input  logic                     i_tx_done,
    output logic [N_REQ-1:0]         o_ack,
    output logic [NB_DATA-1:0]       o_tx_data,
    output logic                     o_tx_start,
    output logic [LOG2_N_REQ-1:0]    o_grant_id,
    output logic                     o_busy,
    output logic                     o_frame_done,
    output logic                     o_timeout
);

    localparam logic [LOG2_N_REQ:0]   N_REQ_W = (LOG2_N_REQ+1)'(N_REQ);
    localparam logic [LOG2_N_REQ-1:0] LAST_ID = LOG2_N_REQ'(N_REQ-1);
    localparam logic [NB_TIMEOUT-1:0] WD_LAST = NB_TIMEOUT'(TIMEOUT_TICKS-1);

    typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_t;

    state_t                  state, state_nxt;
    logic [LOG2_N_REQ-1:0]   rr_ptr, rr_ptr_nxt;
    logic [NB_TIMEOUT-1:0]   wdog, wdog_nxt;
    logic [N_REQ-1:0]        ack_nxt;
    logic [NB_DATA-1:0]      tx_data_nxt;
    logic                    tx_start_nxt;
    logic [LOG2_N_REQ-1:0]   grant_nxt;
    logic                    busy_nxt;
    logic                    frame_done_nxt;
    logic                    timeout_nxt;

    logic [NB_DATA-1:0]      req_byte [N_REQ];
    logic [LOG2_N_REQ:0]     cand_sum;
    logic [LOG2_N_REQ-1:0]   cand_id;
    logic                    win_found;
    logic [LOG2_N_REQ-1:0]   win_id;
    logic [LOG2_N_REQ-1:0]   ptr_after;

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            req_byte[k] = i_data[k*NB_DATA +: NB_DATA];
        end
    end

    // Search upward from the rotating pointer, wrapping at N_REQ-1 back to 0
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand_sum  = '0;
        cand_id   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (LOG2_N_REQ+1)'(k);
            if (cand_sum >= N_REQ_W) begin
                cand_sum = cand_sum - N_REQ_W;
            end
            cand_id = cand_sum[LOG2_N_REQ-1:0];
            if (!win_found && i_req[cand_id]) begin
                win_found = 1'b1;
                win_id    = cand_id;
            end
        end
    end

    assign ptr_after = (o_grant_id == LAST_ID) ? '0 : o_grant_id + 1'b1;

    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        wdog_nxt       = wdog;
        tx_data_nxt    = o_tx_data;
        grant_nxt      = o_grant_id;
        ack_nxt        = '0;
        frame_done_nxt = 1'b0;
        timeout_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt   = LOAD;
                    tx_data_nxt = req_byte[win_id];
                    grant_nxt   = win_id;
                    ack_nxt     = N_REQ'(1) << win_id;
                end
            end
            LOAD: begin
                if (i_valid) begin
                    state_nxt = BUSY;
                    wdog_nxt  = '0;
                end
            end
            BUSY: begin
                // A done arriving on the final watchdog tick still counts as a completed frame
                if (i_tx_done) begin
                    frame_done_nxt = 1'b1;
                    rr_ptr_nxt     = ptr_after;
                    state_nxt      = IDLE;
                end else if (i_valid && (wdog == WD_LAST)) begin
                    timeout_nxt = 1'b1;
                    rr_ptr_nxt  = ptr_after;
                    state_nxt   = IDLE;
                end else if (i_valid) begin
                    wdog_nxt = wdog + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        tx_start_nxt = (state_nxt == LOAD);
        busy_nxt     = (state_nxt != IDLE);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            wdog         <= '0;
            o_ack        <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_grant_id   <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_ptr_nxt;
            wdog         <= wdog_nxt;
            o_ack        <= ack_nxt;
            o_tx_data    <= tx_data_nxt;
            o_tx_start   <= tx_start_nxt;
            o_grant_id   <= grant_nxt;
            o_busy       <= busy_nxt;
            o_frame_done <= frame_done_nxt;
            o_timeout    <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NB_DATA = 8;
    localparam int N_REQ   = 4;
    localparam int LOG2    = 2;
    localparam int TO      = 12;
    localparam int NB_TO   = 4;

    logic                     i_clock = 1'b0;
    logic                     i_reset_n = 1'b1;
    logic [N_REQ-1:0]         i_req = '0;
    logic [N_REQ*NB_DATA-1:0] i_data = '0;
    logic                     i_valid = 1'b0;
    logic                     i_tx_done = 1'b0;
    logic [N_REQ-1:0]         o_ack;
    logic [NB_DATA-1:0]       o_tx_data;
    logic                     o_tx_start;
    logic [LOG2-1:0]          o_grant_id;
    logic                     o_busy;
    logic                     o_frame_done;
    logic                     o_timeout;

    uart_tx_arbiter #(
        .NB_DATA(NB_DATA), .N_REQ(N_REQ), .LOG2_N_REQ(LOG2),
        .TIMEOUT_TICKS(TO), .NB_TIMEOUT(NB_TO)
    ) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_req(i_req), .i_data(i_data),
        .i_valid(i_valid), .i_tx_done(i_tx_done), .o_ack(o_ack), .o_tx_data(o_tx_data),
        .o_tx_start(o_tx_start), .o_grant_id(o_grant_id), .o_busy(o_busy),
        .o_frame_done(o_frame_done), .o_timeout(o_timeout)
    );

    always #5 i_clock = ~i_clock;

    int n_checks = 0;
    int n_pass   = 0;
    int model_ptr = 0;
    logic [NB_DATA-1:0] mdata [N_REQ];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    function automatic int pick(input logic [N_REQ-1:0] mask, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (((mask >> ((ptr + k) % N_REQ)) & 4'b0001) != 4'b0000) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic new_data();
        for (int k = 0; k < N_REQ; k++) mdata[k] = 8'($urandom);
        i_data = {mdata[3], mdata[2], mdata[1], mdata[0]};
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ack"}, 32'(o_ack), 0);
        check({tag, "_data"}, 32'(o_tx_data), 0);
        check({tag, "_grant"}, 32'(o_grant_id), 0);
        check({tag, "_start"}, 32'(o_tx_start), 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_fdone"}, 32'(o_frame_done), 0);
        check({tag, "_tmo"}, 32'(o_timeout), 0);
    endtask

    task automatic do_reset();
        i_req = '0; i_valid = 1'b0; i_tx_done = 1'b0;
        i_reset_n = 1'b0;
        step();
        step();
        check_reset_state("reset");
        i_reset_n = 1'b1;
        model_ptr = 0;
    endtask

    task automatic idle_cycles(input int n);
        i_req = '0; i_valid = 1'b0; i_tx_done = 1'b0;
        for (int c = 0; c < n; c++) begin
            i_valid = 1'($urandom_range(0, 1));
            step();
            check("idle_busy", 32'(o_busy), 0);
            check("idle_ack", 32'(o_ack), 0);
            check("idle_start", 32'(o_tx_start), 0);
        end
        i_valid = 1'b0;
    endtask

    // mode 0: done on busy cycle done_cyc, 1: never done, 2: done together with final watchdog tick
    // vper 0: random ticks, otherwise a tick every vper clocks
    task automatic run_frame(input logic [N_REQ-1:0] mask, input int mode, input int vper,
                             input int load_gap, input int done_cyc, input bit keep_req);
        int win;
        int ticks;
        bit v, d, to, fin;
        logic [N_REQ-1:0] persist;
        win = pick(mask, model_ptr);
        new_data();
        i_req = mask; i_valid = 1'b0; i_tx_done = 1'b0;
        step();
        check("ack", 32'(o_ack), 32'(1 << win));
        check("tx_data", 32'(o_tx_data), 32'(mdata[win]));
        check("grant", 32'(o_grant_id), 32'(win));
        check("start_on", 32'(o_tx_start), 1);
        check("busy_load", 32'(o_busy), 1);
        persist = mask;
        if (!keep_req) persist[win] = 1'b0;
        i_req = persist;
        for (int c = 0; c < load_gap; c++) begin
            i_valid = 1'b0;
            i_tx_done = 1'($urandom_range(0, 1));
            step();
            check("ack_pulse", 32'(o_ack), 0);
            check("start_hold", 32'(o_tx_start), 1);
            check("load_no_done", 32'(o_frame_done), 0);
        end
        i_valid = 1'b1; i_tx_done = 1'b0;
        step();
        check("start_drop", 32'(o_tx_start), 0);
        check("busy_enter", 32'(o_busy), 1);
        check("ack_clear", 32'(o_ack), 0);
        ticks = 0;
        fin = 1'b0;
        for (int c = 0; c < 400; c++) begin
            v = (vper == 0) ? ($urandom_range(0, 2) != 0) : (((c + 1) % vper) == 0);
            d = (mode == 0 && c == done_cyc) || (mode == 2 && v && ticks == TO - 1);
            to = v && (ticks == TO - 1) && !d;
            fin = d || to;
            i_valid = v; i_tx_done = d;
            i_req = persist | 4'($urandom);
            step();
            if (v) ticks++;
            check("frame_done", 32'(o_frame_done), 32'(d));
            check("timeout", 32'(o_timeout), 32'(to));
            check("busy", 32'(o_busy), 32'(!fin));
            if (fin) break;
        end
        check("frame_ended", 32'(fin), 1);
        model_ptr = (win + 1) % N_REQ;
        i_valid = 1'b0; i_tx_done = 1'b0; i_req = persist;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        do_reset();
        idle_cycles(3);

        // single requester, slow ticks, long frame
        run_frame(4'b0100, 0, 16, 15, 159, 1'b0);
        check("t1_data_hold", 32'(o_tx_data), 32'(mdata[2]));
        idle_cycles(2);

        // all requesting continuously: grants rotate 0,1,2,3,0
        do_reset();
        for (int f = 0; f < 5; f++) begin
            run_frame(4'b1111, 0, 0, $urandom_range(0, 3), $urandom_range(0, 10), 1'b1);
            check("rr_order", 32'(o_grant_id), 32'(f % N_REQ));
        end

        // wrap after serving the highest index
        run_frame(4'b1000, 0, 0, 1, 3, 1'b0);
        check("wrap_serve3", 32'(o_grant_id), 3);
        run_frame(4'b1001, 0, 0, 0, 2, 1'b1);
        check("wrap_grant0", 32'(o_grant_id), 0);
        run_frame(4'b1001, 0, 0, 0, 2, 1'b1);
        check("wrap_grant3", 32'(o_grant_id), 3);

        // watchdog abort, then coincident done/timeout
        run_frame(4'b0110, 1, 1, 0, 0, 1'b1);
        run_frame(4'b0110, 0, 1, 2, 4, 1'b0);
        run_frame(4'b1111, 2, 1, 0, 0, 1'b1);
        run_frame(4'b0011, 2, 2, 1, 0, 1'b0);
        idle_cycles(1);

        for (int f = 0; f < 40; f++) begin
            run_frame(4'($urandom_range(1, 15)), $urandom_range(0, 2), 0,
                      $urandom_range(0, 3), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end

        // asynchronous reset in the middle of a frame
        new_data();
        mdata[2] = 8'hA5;
        i_data = {mdata[3], mdata[2], mdata[1], mdata[0]};
        i_req = 4'b0100;
        step();
        i_req = '0; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        check("mid_grant_pre", 32'(o_grant_id), 2);
        check("mid_busy_pre", 32'(o_busy), 1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check_reset_state("async");
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        i_reset_n = 1'b1;
        model_ptr = 0;
        check("post_reset_no_done", 32'(o_frame_done), 0);
        run_frame(4'b0010, 0, 0, 1, 5, 1'b0);
        check("post_reset_grant", 32'(o_grant_id), 1);
        idle_cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
